// File: rtl/reset_release_sequencer_if.sv
// Reset-release sequencer bundle: fabric reset, freeze,
// per-domain ready/reset and status flags.
interface reset_release_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  logic                  FABRIC_RESET_N;
  logic                  FF_US_RESTORE;
  logic [NUM_STAGES-1:0] STAGE_READY;
  logic [NUM_STAGES-1:0] STAGE_RESET_N;
  logic                  ALL_RELEASED;
  logic                  TIMEOUT_ERR;
  logic [2:0]            ERR_STAGE;

  modport master (
    input  FABRIC_RESET_N,
    input  FF_US_RESTORE,
    input  STAGE_READY,
    output STAGE_RESET_N,
    output ALL_RELEASED,
    output TIMEOUT_ERR,
    output ERR_STAGE
  );

  modport slave (
    output FABRIC_RESET_N,
    output FF_US_RESTORE,
    output STAGE_READY,
    input  STAGE_RESET_N,
    input  ALL_RELEASED,
    input  TIMEOUT_ERR,
    input  ERR_STAGE
  );
endinterface

// File: rtl/reset_release_sequencer.sv
// Releases downstream domain resets in order, waiting on each
// domain's ready; unwinds them in reverse when the fabric reset drops.
module reset_release_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic CLK,
  input logic INTERNAL_RST,
  reset_release_sequencer_if.master bus
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES == 0) ? 1
                    : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HW-1:0] HLIM = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST = 3'(NUM_STAGES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;
  localparam logic [2:0] S_UNWIND = 3'd5;

  logic [1:0]            sync;
  logic                  rst_s;
  logic [2:0]            state;
  logic [2:0]            idx;
  logic [HW-1:0]         hcnt;
  logic [TW-1:0]         tcnt;
  logic [NUM_STAGES-1:0] srn;
  logic                  all_rel;
  logic                  terr;
  logic [2:0]            estage;
  logic [NUM_STAGES-1:0] sel;
  logic [NUM_STAGES-1:0] hi;
  logic                  rdy;

  assign rst_s = sync[1];
  assign sel   = NUM_STAGES'(1) << idx;
  assign rdy   = |(bus.STAGE_READY & sel);

  // one-hot of the highest released stage, cleared first on unwind
  always_comb begin
    hi = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (srn[i]) hi = NUM_STAGES'(1) << i;
  end

  always_ff @(posedge CLK or negedge INTERNAL_RST) begin
    if (!INTERNAL_RST) begin
      sync    <= '0;
      state   <= S_IDLE;
      idx     <= '0;
      hcnt    <= '0;
      tcnt    <= '0;
      srn     <= '0;
      all_rel <= 1'b0;
      terr    <= 1'b0;
      estage  <= '0;
    end else begin
      sync <= {sync[0], bus.FABRIC_RESET_N};
      if (!bus.FF_US_RESTORE) begin
        case (state)
          S_IDLE: begin
            srn     <= '0;
            all_rel <= 1'b0;
            if (rst_s) begin
              idx   <= '0;
              hcnt  <= '0;
              terr  <= 1'b0;
              state <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (!rst_s) begin
              all_rel <= 1'b0;
              state   <= S_UNWIND;
            end else if (hcnt == HLIM) begin
              srn   <= srn | sel;
              tcnt  <= '0;
              state <= S_WAIT;
            end else begin
              hcnt <= hcnt + HW'(1);
            end
          end
          S_WAIT: begin
            if (!rst_s) begin
              all_rel <= 1'b0;
              state   <= S_UNWIND;
            end else if (rdy) begin
              if (idx == LAST) begin
                all_rel <= 1'b1;
                state   <= S_DONE;
              end else begin
                idx   <= idx + 3'd1;
                hcnt  <= '0;
                state <= S_HOLD;
              end
            end else if (TIMEOUT_CYCLES != 0) begin
              if (tcnt == TLIM) begin
                terr   <= 1'b1;
                estage <= idx;
                state  <= S_ERROR;
              end else begin
                tcnt <= tcnt + TW'(1);
              end
            end
          end
          S_DONE, S_ERROR: begin
            if (!rst_s) begin
              all_rel <= 1'b0;
              state   <= S_UNWIND;
            end
          end
          S_UNWIND: begin
            if (srn == '0) state <= S_IDLE;
            else           srn   <= srn & ~hi;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.STAGE_RESET_N = srn;
  assign bus.ALL_RELEASED  = all_rel;
  assign bus.TIMEOUT_ERR   = terr;
  assign bus.ERR_STAGE     = estage;
endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: release schedules derived
// arithmetically from ready delays, compared every cycle.
module tb_reset_release_sequencer;
  localparam int NS   = 4;
  localparam int HOLD = 16;
  localparam int TMO  = 1024;
  localparam int INF  = 1 << 28;

  typedef int dly_t [NS];

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  reset_release_sequencer_if #(.NUM_STAGES(NS)) bus ();

  reset_release_sequencer #(
    .NUM_STAGES(NS),
    .HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(clk),
    .INTERNAL_RST(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic fab);
    step();
    bus.FABRIC_RESET_N = fab;
    bus.FF_US_RESTORE  = 1'b0;
    bus.STAGE_READY    = '0;
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // d[k] = cycles after stage k's release before its ready is driven;
  // negative means never. Starts from IDLE with a cleared sync chain.
  task automatic run_release(input dly_t d, input int ncyc,
                             input logic prev_terr);
    int R [NS];
    int t, dn, e, es;
    logic [NS-1:0] srn_e;
    logic all_e, terr_e;
    for (int k = 0; k < NS; k++) R[k] = INF;
    t = 3 + HOLD; dn = INF; e = INF; es = 0;
    for (int k = 0; k < NS; k++) begin
      R[k] = t;
      if (d[k] < 0 || d[k] >= TMO) begin
        e = t + TMO; es = k;
        break;
      end
      t = t + d[k] + 1;
      if (k == NS - 1) dn = t;
      else t = t + HOLD;
    end
    bus.FABRIC_RESET_N = 1'b1;
    bus.STAGE_READY = '0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      srn_e = '0;
      for (int k = 0; k < NS; k++) srn_e[k] = (c >= R[k]);
      all_e  = (c >= dn);
      terr_e = (c < 3) ? prev_terr : (c >= e);
      checks++;
      if (bus.STAGE_RESET_N !== srn_e) begin
        failures++;
        $display("FAIL release_srn c=%0d got=%b exp=%b",
                 c, bus.STAGE_RESET_N, srn_e);
      end
      checks++;
      if (bus.ALL_RELEASED !== all_e) begin
        failures++;
        $display("FAIL release_all c=%0d got=%b exp=%b",
                 c, bus.ALL_RELEASED, all_e);
      end
      checks++;
      if (bus.TIMEOUT_ERR !== terr_e) begin
        failures++;
        $display("FAIL release_terr c=%0d got=%b exp=%b",
                 c, bus.TIMEOUT_ERR, terr_e);
      end
      if (c >= e) begin
        checks++;
        if (bus.ERR_STAGE !== 3'(es)) begin
          failures++;
          $display("FAIL err_stage c=%0d got=%0d exp=%0d",
                   c, bus.ERR_STAGE, es);
        end
      end
      for (int k = 0; k < NS; k++)
        bus.STAGE_READY[k] = (d[k] >= 0) && (R[k] != INF)
                             && (c >= R[k] + d[k]);
    end
  endtask

  // drop the fabric reset with n stages released; expect reverse unwind
  task automatic do_unwind(input int n, input logic all_b,
                           input logic terr_e, input int es);
    int m;
    logic [NS-1:0] srn_e;
    logic all_e;
    bus.FABRIC_RESET_N = 1'b0;
    for (int c = 1; c <= n + 8; c++) begin
      step();
      m = (c < 3) ? n : n - (c - 3);
      if (m < 0) m = 0;
      srn_e = NS'((1 << m) - 1);
      all_e = (c < 3) ? all_b : 1'b0;
      checks++;
      if (bus.STAGE_RESET_N !== srn_e) begin
        failures++;
        $display("FAIL unwind_srn c=%0d got=%b exp=%b",
                 c, bus.STAGE_RESET_N, srn_e);
      end
      checks++;
      if (bus.ALL_RELEASED !== all_e) begin
        failures++;
        $display("FAIL unwind_all c=%0d got=%b exp=%b",
                 c, bus.ALL_RELEASED, all_e);
      end
      checks++;
      if (bus.TIMEOUT_ERR !== terr_e) begin
        failures++;
        $display("FAIL unwind_terr c=%0d got=%b exp=%b",
                 c, bus.TIMEOUT_ERR, terr_e);
      end
      if (terr_e) begin
        checks++;
        if (bus.ERR_STAGE !== 3'(es)) begin
          failures++;
          $display("FAIL unwind_estage c=%0d got=%0d exp=%0d",
                   c, bus.ERR_STAGE, es);
        end
      end
    end
  endtask

  task automatic test_reset;
    bus.FABRIC_RESET_N = 1'b0;
    bus.FF_US_RESTORE  = 1'b0;
    bus.STAGE_READY    = '0;
    rst = 1'b0;
    #12;
    checks++;
    if ({bus.STAGE_RESET_N, bus.ALL_RELEASED, bus.TIMEOUT_ERR,
         bus.ERR_STAGE} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%b/%b/%0d exp=0",
               bus.STAGE_RESET_N, bus.ALL_RELEASED,
               bus.TIMEOUT_ERR, bus.ERR_STAGE);
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_in_order;
    dly_t d = '{0, 0, 0, 0};
    run_release(d, 80, 1'b0);
    do_unwind(NS, 1'b1, 1'b0, 0);
  endtask

  task automatic test_random_delays;
    dly_t d;
    for (int k = 0; k < NS; k++) d[k] = int'($urandom_range(0, 15));
    run_release(d, 170, 1'b0);
    do_unwind(NS, 1'b1, 1'b0, 0);
  endtask

  task automatic test_timeout(output int s);
    dly_t d;
    s = int'($urandom_range(0, NS - 1));
    for (int k = 0; k < NS; k++)
      d[k] = (k == s) ? -1 : int'($urandom_range(0, 5));
    run_release(d, 1200, 1'b0);
    do_unwind(s + 1, 1'b0, 1'b1, s);
  endtask

  task automatic test_back_to_back;
    dly_t d;
    for (int k = 0; k < NS; k++) d[k] = int'($urandom_range(0, 8));
    run_release(d, 150, 1'b1);
    do_unwind(NS, 1'b1, 1'b0, 0);
  endtask

  task automatic test_ready_race;
    dly_t d = '{0, 0, TMO - 1, 0};
    run_release(d, 1120, 1'b0);
    do_unwind(NS, 1'b1, 1'b0, 0);
  endtask

  // freeze mid-HOLD of stage 1 for 50 edges; fabric dips low meanwhile
  task automatic test_freeze(input logic come_back);
    logic [NS-1:0] srn_e;
    apply_reset(1'b0);
    bus.FABRIC_RESET_N = 1'b1;
    bus.STAGE_READY = '1;
    for (int c = 1; c <= 92; c++) begin
      step();
      if (come_back)
        srn_e = {2'b00, c >= 86, c >= 19};
      else
        srn_e = {3'b000, (c >= 19) && (c < 77)};
      checks++;
      if (bus.STAGE_RESET_N !== srn_e) begin
        failures++;
        $display("FAIL freeze_srn back=%0b c=%0d got=%b exp=%b",
                 come_back, c, bus.STAGE_RESET_N, srn_e);
      end
      checks++;
      if (bus.ALL_RELEASED !== 1'b0) begin
        failures++;
        $display("FAIL freeze_all c=%0d got=%b exp=0",
                 c, bus.ALL_RELEASED);
      end
      if (c == 25) bus.FF_US_RESTORE = 1'b1;
      if (c == 40) bus.FABRIC_RESET_N = 1'b0;
      if (c == 50 && come_back) bus.FABRIC_RESET_N = 1'b1;
      if (c == 75) bus.FF_US_RESTORE = 1'b0;
    end
  endtask

  task automatic test_async_reset;
    dly_t d  = '{0, -1, 0, 0};
    dly_t d0 = '{0, 0, 0, 0};
    apply_reset(1'b0);
    run_release(d, 50, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.STAGE_RESET_N, bus.ALL_RELEASED, bus.TIMEOUT_ERR,
         bus.ERR_STAGE} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b/%b/%b/%0d exp=0",
               bus.STAGE_RESET_N, bus.ALL_RELEASED,
               bus.TIMEOUT_ERR, bus.ERR_STAGE);
    end
    bus.STAGE_READY = '0;
    step();
    rst = 1'b1;
    run_release(d0, 80, 1'b0);
  endtask

  initial begin
    int s;
    checks = 0;
    failures = 0;
    test_reset();
    test_in_order();
    test_random_delays();
    test_timeout(s);
    test_back_to_back();
    test_ready_race();
    test_freeze(1'b1);
    test_freeze(1'b0);
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
